uart_tx: RTL



---
 rtl/uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: frames one parallel word per request onto the tx line
// (start, data LSB-first, optional parity, 1 or 2 stop bits), paced by baud_tick.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned SH_W  = DATA_BITS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_SENSE  = (PARITY_ODD != 0);
  localparam logic TWO_STOP   = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;   // {parity, data}; shifted right as bits go out
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state and next-line decode; everything past accept waits for baud_tick.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shreg_d = {(^tx_data) ^ ODD_SENSE, tx_data};
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q != LAST_IDX) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end else if (HAS_PARITY) begin
            // After the data shifts, the parity bit sits at the bottom.
            tx_d    = shreg_q[0];
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (TWO_STOP && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            tx_done = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake status is a direct decode of the state.
  always_comb begin
    tx_ready = (state_q == S_IDLE);
    tx_busy  = (state_q != S_IDLE);
  end

  assign tx = tx_q;

endmodule
